// File: rtl/bus_io_port.sv
// Memory-mapped I/O responder on the shared tri-state sysbus.
// Buffers CPU writes in a small FIFO that drains to the display at a programmable interval,
// and presents debounced switch inputs with change and overflow status.
// Optional feature macro: IO_IRQ_EN adds a registered irq output and turns RATE[7] into
// the empty-interrupt enable.
module bus_io_port #(
    parameter int unsigned              WORD_W     = 8,
    parameter int unsigned              OP_W       = 3,
    parameter logic [WORD_W-OP_W-1:0]   IO_BASE    = 5'b11100,
    parameter int unsigned              FIFO_DEPTH = 4,
    parameter int unsigned              DEBOUNCE   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    inout  wire  [WORD_W-1:0]      sysbus,
    input  logic [WORD_W-OP_W-1:0] address,
    input  logic                   CS,
    input  logic                   R_NW,
    input  logic [WORD_W-1:0]      switches,
`ifdef IO_IRQ_EN
    output logic                   irq,
`endif
    output logic [WORD_W-1:0]      display
);

    localparam int unsigned AW  = WORD_W - OP_W;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned DBW = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] OffData   = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffSwitch = 2'd2;
    localparam logic [1:0] OffRate   = 2'd3;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [3:0]        count_q;
    logic [WORD_W-1:0] display_q;
    logic [WORD_W-1:0] rate_q;
    logic [WORD_W-1:0] drain_q;
    logic              ovf_q, chg_q;
    logic [WORD_W-1:0] sync1_q, sync2_q, stable_q, cand_q;
    logic [DBW-1:0]    db_cnt_q;
    logic              cs_q;

    logic              hit, first, wr_en, rd_en;
    logic [1:0]        offset;
    logic              empty, full, pop, push, ovf_set;
    logic [WORD_W-1:0] status, rdata, interval;
    logic [DBW-1:0]    db_run;
    logic              sw_accept;

    // Decode the access, detect the first cycle of a hit window and work out FIFO traffic.
    always_comb begin
        hit     = CS && (address[AW-1:2] == IO_BASE[AW-1:2]);
        first   = hit && !cs_q;
        offset  = address[1:0];
        wr_en   = first && !R_NW;
        rd_en   = first && R_NW;
        empty   = (count_q == 4'd0);
        full    = (count_q == 4'(FIFO_DEPTH));
        pop     = (drain_q == '0) && !empty;
        // A write while full still lands if the head leaves on the same edge.
        push    = wr_en && (offset == OffData) && (!full || pop);
        ovf_set = wr_en && (offset == OffData) && full && !pop;
    end

    // Status word and read mux.
    always_comb begin
        status      = '0;
        status[7:0] = {ovf_q, chg_q, full, empty, count_q};
        rdata       = '0;
        case (offset)
            OffStatus: rdata = status;
            OffSwitch: rdata = stable_q;
            OffRate:   rdata = rate_q;
            default:   rdata = '0;
        endcase
    end

    // Drain interval; bit 7 is reserved for the interrupt enable when irq is present.
    always_comb begin
`ifdef IO_IRQ_EN
        interval      = '0;
        interval[6:0] = rate_q[6:0];
`else
        interval      = rate_q;
`endif
    end

    // Debounce: length of the current run of identical synchronised values that differ
    // from the accepted value.
    always_comb begin
        db_run    = '0;
        sw_accept = 1'b0;
        if (sync2_q != stable_q) begin
            db_run    = (sync2_q == cand_q) ? db_cnt_q + 1'b1 : DBW'(1);
            sw_accept = (db_run >= DBW'(DEBOUNCE));
        end
    end

    // Reset gates the driver so the bus releases the instant reset asserts.
    assign sysbus  = (hit && R_NW && !reset) ? rdata : 'z;
    assign display = display_q;

    // FIFO storage; contents are discarded logically by resetting the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= sysbus;
        end
    end

    // FIFO pointers, occupancy, drain counter and display register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drain_q   <= '0;
            display_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                display_q <= mem[rd_ptr_q];
                rd_ptr_q  <= ptr_inc(rd_ptr_q);
                drain_q   <= interval;
            end else if (drain_q != '0) begin
                drain_q <= drain_q - 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 4'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 4'd1;
            end
        end
    end

    // Bus-side registers: access edge detector, RATE and sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_q   <= 1'b0;
            rate_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cs_q <= hit;
            if (wr_en && (offset == OffRate)) begin
                rate_q <= sysbus;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (rd_en && (offset == OffStatus)) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Switch synchroniser, debounce and change flag; a set beats a same-cycle read clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cand_q   <= '0;
            db_cnt_q <= '0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q <= switches;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (sw_accept) begin
                stable_q <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                cand_q   <= sync2_q;
                db_cnt_q <= db_run;
            end
            if (sw_accept) begin
                chg_q <= 1'b1;
            end else if (rd_en && (offset == OffSwitch)) begin
                chg_q <= 1'b0;
            end
        end
    end

`ifdef IO_IRQ_EN
    logic irq_q;

    // Registered interrupt request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= chg_q || ovf_q || (rate_q[7] && empty);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_bus_io_port.sv
// Self-checking bench for bus_io_port: directed scenarios plus random bus traffic,
// checked by a scoreboard fed from a behavioural model of the register window.
module tb_bus_io_port;

    localparam int DEPTH = 4;
    localparam int DEB   = 3;

    localparam logic [4:0] A_DATA   = 5'b11100;
    localparam logic [4:0] A_STATUS = 5'b11101;
    localparam logic [4:0] A_SWITCH = 5'b11110;
    localparam logic [4:0] A_RATE   = 5'b11111;

    logic       clock = 1'b0;
    logic       reset;
    logic       cs    = 1'b0;
    logic       rnw   = 1'b0;
    logic [4:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic [7:0] sw    = '0;
    logic [7:0] display;
    wire  [7:0] sysbus;

    assign sysbus = (cs && !rnw) ? wdata : 8'bz;

    bus_io_port #(
        .WORD_W     (8),
        .OP_W       (3),
        .IO_BASE    (5'b11100),
        .FIFO_DEPTH (DEPTH),
        .DEBOUNCE   (DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sysbus   (sysbus),
        .address  (addr),
        .CS       (cs),
        .R_NW     (rnw),
        .switches (sw),
        .display  (display)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] v;
        int         c;
    } disp_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         rd_check = 1'b0;
    logic [7:0] last_rd  = '0;
    logic [7:0] prev_disp = '0;
    logic [7:0] exp_rd[$];
    disp_t      exp_disp[$];

    // Behavioural model state.
    logic [7:0] m_q[$];
    logic [7:0] m_sh[$];
    logic [7:0] m_disp, m_rate, m_stable, m_sync1, m_sync2;
    int         m_cnt;
    bit         m_ovf, m_chg, m_csq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] off);
        case (off)
            2'd1: return {m_ovf, m_chg, m_q.size() == DEPTH, m_q.size() == 0,
                          4'(m_q.size())};
            2'd2: return m_stable;
            2'd3: return m_rate;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        if (m_disp != 8'h00) exp_disp.push_back('{v: 8'h00, c: cyc});
        m_q.delete();
        m_sh.delete();
        m_disp = 0; m_rate = 0; m_cnt = 0; m_ovf = 0; m_chg = 0;
        m_stable = 0; m_sync1 = 0; m_sync2 = 0; m_csq = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit         hit, first, wr, rd, full, pop, push, ovf_set, accept;
        logic [1:0] off;
        logic [7:0] s;
        hit     = cs && (addr[4:2] == 3'b111);
        first   = hit && !m_csq;
        off     = addr[1:0];
        wr      = first && !rnw;
        rd      = first && rnw;
        full    = (m_q.size() == DEPTH);
        pop     = (m_cnt == 0) && (m_q.size() != 0);
        push    = wr && (off == 2'd0) && (!full || pop);
        ovf_set = wr && (off == 2'd0) && full && !pop;
        // Accept once the last DEB synchronised samples all agree and differ from stable.
        s = m_sync2;
        m_sh.push_back(s);
        if (m_sh.size() > DEB) void'(m_sh.pop_front());
        accept = (m_sh.size() == DEB) && (s != m_stable);
        foreach (m_sh[i]) if (m_sh[i] != s) accept = 0;
        if (pop) begin
            m_disp = m_q.pop_front();
            exp_disp.push_back('{v: m_disp, c: cyc});
            m_cnt = int'(m_rate);
        end else if (m_cnt > 0) begin
            m_cnt--;
        end
        if (push) m_q.push_back(wdata);
        if (wr && off == 2'd3) m_rate = wdata;
        if (ovf_set) m_ovf = 1;
        else if (rd && off == 2'd1) m_ovf = 0;
        if (accept) begin
            m_stable = s;
            m_chg    = 1;
        end else if (rd && off == 2'd2) begin
            m_chg = 0;
        end
        m_sync2 = m_sync1;
        m_sync1 = sw;
        m_csq   = hit;
    endtask

    // One clock with the current inputs; queues the expected bus value when the bench is
    // not driving it.
    task automatic tick();
        if (!(cs && !rnw)) begin
            if (cs && rnw && addr[4:2] == 3'b111) exp_rd.push_back(model_read(addr[1:0]));
            else exp_rd.push_back(8'bz);
            rd_check = 1'b1;
        end else begin
            rd_check = 1'b0;
        end
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic bus_op(input bit r, input logic [4:0] a, input logic [7:0] d,
                          input int hold);
        cs = 1'b1; rnw = r; addr = a; wdata = d;
        repeat (hold) tick();
        cs = 1'b0; rnw = 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Asynchronous reset asserted between edges while a STATUS read is on the bus.
    task automatic reset_pulse();
        rd_check = 1'b0;
        cs = 1'b1; rnw = 1'b1; addr = A_STATUS;
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_sysbus_released", {24'b0, sysbus}, {24'b0, 8'bz});
        check("reset_display_zero", {24'b0, display}, 32'h0);
        @(posedge clock);
        cyc++;
        #1;
        cs = 1'b0; rnw = 1'b0;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: bus values every cycle, display on every change.
    always @(negedge clock) begin
        if (rd_check) begin
            if (exp_rd.size() == 0) begin
                checks++; failures++;
                $display("FAIL sysbus_no_expectation actual=%h (cycle %0d)", sysbus, cyc);
            end else begin
                logic [7:0] e;
                e = exp_rd.pop_front();
                if (cs && rnw) last_rd = sysbus;
                check("sysbus_value", {24'b0, sysbus}, {24'b0, e});
            end
        end
        if (display !== prev_disp) begin
            if (exp_disp.size() == 0) begin
                checks++; failures++;
                $display("FAIL display_unexpected_change actual=%h previous=%h (cycle %0d)",
                         display, prev_disp, cyc);
            end else begin
                disp_t d;
                d = exp_disp.pop_front();
                check("display_value", {24'b0, display}, {24'b0, d.v});
                check("display_cycle", cyc, d.c);
            end
            prev_disp = display;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // RATE=0: a pushed value appears one edge after the write edge.
        bus_op(1'b0, A_RATE, 8'h00, 1);
        cs = 1'b1; rnw = 1'b0; addr = A_DATA; wdata = 8'hA5;
        tick();
        cs = 1'b0;
        tick();
        check("rate0_display_next_edge", {24'b0, display}, 32'hA5);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("rate0_status_after", {24'b0, last_rd}, 32'h10);

        // RATE=3: three writes drain at four-cycle intervals without overflow.
        bus_op(1'b0, A_RATE, 8'h03, 1);
        bus_op(1'b0, A_DATA, 8'h01, 1);
        bus_op(1'b0, A_DATA, 8'h02, 1);
        bus_op(1'b0, A_DATA, 8'h03, 1);
        idle(12);
        check("rate3_display_last", {24'b0, display}, 32'h03);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("rate3_status_no_ovf", {24'b0, last_rd}, 32'h10);

        // RATE=FF: first value drains at once, then four fill the FIFO and one overflows.
        bus_op(1'b0, A_RATE, 8'hFF, 1);
        bus_op(1'b0, A_DATA, 8'h11, 1);
        for (int i = 0; i < 5; i++) bus_op(1'b0, A_DATA, 8'(8'h40 + i), 1);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("full_status_ovf", {24'b0, last_rd}, 32'hA4);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("full_status_ovf_cleared", {24'b0, last_rd}, 32'h24);

        // Reset mid-drain with three entries queued.
        reset_pulse();
        bus_op(1'b0, A_RATE, 8'hFF, 1);
        for (int i = 0; i < 4; i++) bus_op(1'b0, A_DATA, 8'(8'h71 + i), 1);
        reset_pulse();
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("post_reset_status", {24'b0, last_rd}, 32'h10);

        // Switch debounce: a held change is accepted, a two-cycle glitch is not.
        sw = 8'h3C;
        idle(6);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("sw_changed_set", {24'b0, last_rd}, 32'h50);
        bus_op(1'b1, A_SWITCH, 8'h00, 1);
        check("sw_value", {24'b0, last_rd}, 32'h3C);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("sw_changed_cleared", {24'b0, last_rd}, 32'h10);
        sw = 8'hFF;
        idle(2);
        sw = 8'h3C;
        idle(8);
        bus_op(1'b1, A_SWITCH, 8'h00, 1);
        check("sw_glitch_rejected", {24'b0, last_rd}, 32'h3C);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("sw_glitch_no_change", {24'b0, last_rd}, 32'h10);

        // Held CS gives exactly one push; an access outside the window does nothing.
        bus_op(1'b0, A_RATE, 8'hFF, 1);
        bus_op(1'b0, A_DATA, 8'h22, 1);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("hold_status_before", {24'b0, last_rd}, 32'h10);
        bus_op(1'b0, A_DATA, 8'h33, 3);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("hold_single_push", {24'b0, last_rd}, 32'h01);
        bus_op(1'b0, 5'b00011, 8'h5A, 1);
        bus_op(1'b1, 5'b00011, 8'h00, 1);
        bus_op(1'b1, A_STATUS, 8'h00, 1);
        check("miss_status_unchanged", {24'b0, last_rd}, 32'h01);
        bus_op(1'b1, A_RATE, 8'h00, 1);
        check("miss_rate_unchanged", {24'b0, last_rd}, 32'hFF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int k;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) sw = 8'($urandom);
                else sw = sw ^ (8'h01 << $urandom_range(0, 7));
            end
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3: bus_op(1'b0, A_DATA, 8'($urandom), $urandom_range(1, 3));
                4: bus_op(1'b0, A_RATE, 8'($urandom_range(0, 5)), 1);
                5: bus_op(1'b1, A_STATUS, 8'h00, $urandom_range(1, 2));
                6: bus_op(1'b1, A_SWITCH, 8'h00, 1);
                7: bus_op(1'($urandom), {3'b111, 2'($urandom)}, 8'($urandom),
                          $urandom_range(1, 2));
                8: bus_op(1'($urandom), {3'($urandom_range(0, 6)), 2'($urandom)},
                          8'($urandom), 1);
                default: idle($urandom_range(1, 3));
            endcase
        end

        // Drain everything and confirm the scoreboard emptied.
        bus_op(1'b0, A_RATE, 8'h00, 1);
        idle(300);
        check("final_display", {24'b0, display}, {24'b0, m_disp});
        check("final_disp_queue_empty", exp_disp.size(), 0);
        check("final_rd_queue_empty", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
